mult_booth_r4_seq: RTL and testbench

- Parametrised iterative radix-4 Booth multiplier. Successor to the fixed 32-bit single-step Booth stage.
- Owns its own accumulator, iteration counter and control FSM. Uses a start/ready handshake.
- Supports signed and unsigned operands, selected per operation.
- Sits in the multdiv unit and feeds the processor writeback mux; the multdiv control logic stalls the pipeline while busy=1.

---
 rtl/mult_booth_r4_seq.sv | 155 +++++++++++++++
 tb/tb_mult_booth_r4_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_booth_r4_seq.sv
// rtl/mult_booth_r4_seq.sv - iterative radix-4 Booth multiplier with start/ready handshake
// Optional overflow flag is built only when MULT_BOOTH_OVF_EN is defined.
module mult_booth_r4_seq #(
   parameter int WIDTH = 32
) (
   input  logic               clock,
   input  logic               clear_n,
   input  logic               start,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic [2*WIDTH-1:0] product,
   output logic               ready,
   output logic               busy,
   output logic               overflow
);
   localparam int ITER = WIDTH / 2 + 1;
   localparam int EW   = WIDTH + 2;
   localparam int AW   = WIDTH + 3;
   localparam int CW   = $clog2(ITER + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_next;
   logic [AW-1:0]   acc;
   logic [EW-1:0]   q_reg;
   logic            qm1;
   logic [EW-1:0]   m_reg;
   logic [CW-1:0]   cnt;

   logic            load, step, finish;
   logic            neg, dbl, nz;
   logic [AW-1:0]   mag, addend, sum, acc_shift;
   logic [EW-1:0]   q_shift;
   logic [2*WIDTH-1:0] product_next;
   logic [AW+EW-2*WIDTH-1:0] prod_unused;

   function automatic logic [EW-1:0] ext(input logic [WIDTH-1:0] x, input logic sx);
      return sx ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
   endfunction

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      ready      = 1'b0;
      busy       = 1'b0;
      load       = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            step = 1'b1;
            if (cnt == CW'(1)) begin
               finish     = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            ready = 1'b1;
            if (start) begin
               load       = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Booth window {q[2i+1], q[2i], q[2i-1]} selects the digit for this step
   always_comb begin
      neg = 1'b0;
      dbl = 1'b0;
      nz  = 1'b1;
      case ({q_reg[1:0], qm1})
         3'b000, 3'b111: nz = 1'b0;
         3'b001, 3'b010: ;
         3'b011: dbl = 1'b1;
         3'b100: begin neg = 1'b1; dbl = 1'b1; end
         default: neg = 1'b1;
      endcase
   end

   always_comb begin
      mag = '0;
      if (nz) mag = dbl ? {m_reg, 1'b0} : {m_reg[EW-1], m_reg};
      addend    = neg ? ~mag : mag;
      sum       = acc + addend + AW'(neg);
      acc_shift = {{2{sum[AW-1]}}, sum[AW-1:2]};
      q_shift   = {sum[1:0], q_reg[EW-1:2]};
   end

   assign {prod_unused, product_next} = {acc_shift, q_shift};

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         acc     <= '0;
         q_reg   <= '0;
         qm1     <= 1'b0;
         m_reg   <= '0;
         cnt     <= '0;
         product <= '0;
      end else if (load) begin
         acc   <= '0;
         q_reg <= ext(multiplier, is_signed);
         qm1   <= 1'b0;
         m_reg <= ext(multiplicand, is_signed);
         cnt   <= CW'(ITER);
      end else if (step) begin
         acc   <= acc_shift;
         q_reg <= q_shift;
         qm1   <= q_reg[1];
         cnt   <= cnt - 1'b1;
         if (finish) product <= product_next;
      end
   end

`ifdef MULT_BOOTH_OVF_EN
   logic sgn_reg, ovf_reg, ovf_next;

   always_comb begin
      if (sgn_reg)
         ovf_next = !((&product_next[2*WIDTH-1:WIDTH-1]) || !(|product_next[2*WIDTH-1:WIDTH-1]));
      else
         ovf_next = |product_next[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         sgn_reg <= 1'b0;
         ovf_reg <= 1'b0;
      end else begin
         if (load)   sgn_reg <= is_signed;
         if (finish) ovf_reg <= ovf_next;
      end
   end

   assign overflow = ovf_reg;
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_mult_booth_r4_seq.sv
// tb/tb_mult_booth_r4_seq.sv - directed table and random checks for mult_booth_r4_seq
// Overflow expectations follow MULT_BOOTH_OVF_EN.
module tb_mult_booth_r4_seq;
`ifdef MULT_BOOTH_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif
   localparam int LIMIT = 40;

   logic        clock, clear_n;
   logic        start32, s32, ready32, busy32, ovf32;
   logic [31:0] m32, q32;
   logic [63:0] p32;
   logic        start8, s8, ready8, busy8, ovf8;
   logic [7:0]  m8, q8;
   logic [15:0] p8;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        s;
      logic [31:0] m;
      logic [31:0] q;
      logic [63:0] p;
      logic        ovf;
   } vec_t;
   vec_t tbl[12];

   mult_booth_r4_seq #(.WIDTH(32)) dut32 (
      .clock(clock), .clear_n(clear_n), .start(start32), .is_signed(s32),
      .multiplicand(m32), .multiplier(q32), .product(p32),
      .ready(ready32), .busy(busy32), .overflow(ovf32));

   mult_booth_r4_seq #(.WIDTH(8)) dut8 (
      .clock(clock), .clear_n(clear_n), .start(start8), .is_signed(s8),
      .multiplicand(m8), .multiplier(q8), .product(p8),
      .ready(ready8), .busy(busy8), .overflow(ovf8));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] ref32(input logic s, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] xa, xb;
      xa = s ? {{32{a[31]}}, a} : {32'b0, a};
      xb = s ? {{32{b[31]}}, b} : {32'b0, b};
      return xa * xb;
   endfunction

   function automatic logic [15:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
      logic [15:0] xa, xb;
      xa = s ? {{8{a[7]}}, a} : {8'b0, a};
      xb = s ? {{8{b[7]}}, b} : {8'b0, b};
      return xa * xb;
   endfunction

   task automatic wait32(output int lat, output int bcnt);
      lat = 0;
      bcnt = 0;
      while (!ready32 && lat < LIMIT) begin
         if (busy32) bcnt++;
         @(negedge clock);
         lat++;
      end
      if (!ready32) chk("timeout32", 64'(lat), 64'(LIMIT + 1));
   endtask

   task automatic op32(input logic s, input logic [31:0] m, input logic [31:0] q,
                       output int lat, output int bcnt);
      @(negedge clock);
      s32 = s; m32 = m; q32 = q; start32 = 1'b1;
      @(negedge clock);
      start32 = 1'b0;
      wait32(lat, bcnt);
   endtask

   task automatic op8(input logic s, input logic [7:0] m, input logic [7:0] q, output int lat);
      @(negedge clock);
      s8 = s; m8 = m; q8 = q; start8 = 1'b1;
      @(negedge clock);
      start8 = 1'b0;
      lat = 0;
      while (!ready8 && lat < LIMIT) begin
         @(negedge clock);
         lat++;
      end
      if (!ready8) chk("timeout8", 64'(lat), 64'(LIMIT + 1));
   endtask

   initial begin
      int lat, bcnt;
      logic saw;
      logic [15:0] e8;
      logic [63:0] e32;
      logic eo;
      vec_t v;

      tbl[0]  = '{1'b1, 32'd3,         32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFF4, 1'b0};
      tbl[1]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b1};
      tbl[2]  = '{1'b1, 32'h80000000,  32'h80000000, 64'h4000000000000000, 1'b1};
      tbl[3]  = '{1'b1, 32'h7FFFFFFF,  32'h7FFFFFFF, 64'h3FFFFFFF00000001, 1'b1};
      tbl[4]  = '{1'b0, 32'd5,         32'd7,        64'd35,               1'b0};
      tbl[5]  = '{1'b1, 32'hFFFFFFFF,  32'hFFFFFFFF, 64'd1,                1'b0};
      tbl[6]  = '{1'b0, 32'h80000000,  32'd2,        64'h0000000100000000, 1'b1};
      tbl[7]  = '{1'b1, 32'd0,         32'h12345678, 64'd0,                1'b0};
      tbl[8]  = '{1'b1, 32'h80000000,  32'h7FFFFFFF, 64'hC000000080000000, 1'b1};
      tbl[9]  = '{1'b0, 32'h00010000,  32'h00010000, 64'h0000000100000000, 1'b1};
      tbl[10] = '{1'b1, 32'h00010000,  32'hFFFF0000, 64'hFFFFFFFF00000000, 1'b1};
      tbl[11] = '{1'b1, 32'hFFFF8000,  32'h00010000, 64'hFFFFFFFF80000000, 1'b0};

      clear_n = 1'b0;
      start32 = 1'b0; s32 = 1'b0; m32 = '0; q32 = '0;
      start8 = 1'b0;  s8 = 1'b0;  m8 = '0;  q8 = '0;
      repeat (3) @(negedge clock);
      chk("reset_p32", p32, 64'd0);
      chk("reset_ctl32", {61'd0, ready32, busy32, ovf32}, 64'd0);
      chk("reset_p8", 64'(p8), 64'd0);
      chk("reset_ctl8", {61'd0, ready8, busy8, ovf8}, 64'd0);
      clear_n = 1'b1;
      @(negedge clock);

      for (int i = 0; i < 12; i++) begin
         v = tbl[i];
         op32(v.s, v.m, v.q, lat, bcnt);
         chk($sformatf("tbl%0d_product", i), p32, v.p);
         chk($sformatf("tbl%0d_overflow", i), 64'(ovf32), 64'(v.ovf & OVF_EN));
         chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'd17);
         chk($sformatf("tbl%0d_busy_cycles", i), 64'(bcnt), 64'd17);
         chk($sformatf("tbl%0d_busy_at_ready", i), 64'(busy32), 64'd0);
         @(negedge clock);
         chk($sformatf("tbl%0d_ready_pulse", i), 64'(ready32), 64'd0);
      end

      // start held with new operands during RUN must be ignored
      op32(1'b0, 32'd5, 32'd7, lat, bcnt);
      @(negedge clock);
      s32 = 1'b1; m32 = 32'd3; q32 = 32'hFFFFFFFC; start32 = 1'b1;
      @(negedge clock);
      m32 = 32'd9; q32 = 32'd9;
      repeat (10) @(negedge clock);
      start32 = 1'b0;
      chk("hold_product_stable", p32, 64'd35);
      wait32(lat, bcnt);
      chk("hold_latency", 64'(lat), 64'd7);
      chk("hold_product", p32, 64'hFFFFFFFFFFFFFFF4);

      // start in the DONE cycle: back-to-back operation
      s32 = 1'b0; m32 = 32'd5; q32 = 32'd7; start32 = 1'b1;
      @(negedge clock);
      start32 = 1'b0;
      chk("b2b_busy", 64'(busy32), 64'd1);
      chk("b2b_product_held", p32, 64'hFFFFFFFFFFFFFFF4);
      wait32(lat, bcnt);
      chk("b2b_latency", 64'(lat), 64'd17);
      chk("b2b_product", p32, 64'd35);
      @(negedge clock);

      // asynchronous reset mid-operation
      @(negedge clock);
      s32 = 1'b0; m32 = 32'h1234; q32 = 32'h5678; start32 = 1'b1;
      @(negedge clock);
      start32 = 1'b0;
      repeat (8) @(negedge clock);
      #2 clear_n = 1'b0;
      #1;
      chk("async_rst_product", p32, 64'd0);
      chk("async_rst_ctl", {61'd0, ready32, busy32, ovf32}, 64'd0);
      @(negedge clock);
      @(negedge clock);
      clear_n = 1'b1;
      saw = 1'b0;
      repeat (20) begin
         @(negedge clock);
         if (ready32 || busy32) saw = 1'b1;
      end
      chk("rst_no_ready", 64'(saw), 64'd0);
      op32(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
      chk("after_rst_product", p32, 64'd1);
      chk("after_rst_latency", 64'(lat), 64'd17);
      @(negedge clock);

      // narrow instance corner
      op8(1'b1, 8'h80, 8'hFF, lat);
      chk("w8_product", 64'(p8), 64'h0080);
      chk("w8_overflow", 64'(ovf8), 64'(OVF_EN));
      chk("w8_latency", 64'(lat), 64'd5);
      @(negedge clock);

      for (int mode = 0; mode < 2; mode++) begin
         for (int n = 0; n < 1000; n++) begin
            op8(mode[0], 8'($urandom), 8'($urandom), lat);
            e8 = ref8(s8, m8, q8);
            eo = s8 ? !((&e8[15:7]) || !(|e8[15:7])) : |e8[15:8];
            chk($sformatf("rand8_m%0d_%h_%h", mode, m8, q8),
                {39'd0, p8, ovf8, 8'(lat)}, {39'd0, e8, eo & OVF_EN, 8'd5});
         end
         for (int n = 0; n < 100; n++) begin
            op32(mode[0], $urandom, $urandom, lat, bcnt);
            e32 = ref32(s32, m32, q32);
            eo = s32 ? !((&e32[63:31]) || !(|e32[63:31])) : |e32[63:32];
            chk($sformatf("rand32_m%0d_%h_%h_p", mode, m32, q32), p32, e32);
            chk($sformatf("rand32_m%0d_%h_%h_o", mode, m32, q32),
                {55'd0, ovf32, 8'(lat)}, {55'd0, eo & OVF_EN, 8'd17});
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
